prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 183 ++++++++++++++++++
 tb/tb_prog_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the single-cycle RISC-V core.
// Accepts a length-prefixed, little-endian image over a valid/ready byte
// port, writes each assembled 32-bit word into the instruction memory and
// holds the core in reset (cpu_rstn=0) until the whole image has landed.
// Optional feature: define LOADER_CHECKSUM_EN to expect one trailing byte
// equal to the XOR of all header and data bytes.
//
// Handshake: a byte is transferred on every rising edge where
// in_valid && in_ready; in_valid may drop at any byte position and all
// partial state is held until the next accepted byte.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Largest legal word count: the full IM capacity.
    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;        // byte position within header/word
    logic [23:0]         sr_q, sr_d;          // first three bytes of the current word
    logic [ADDR_W:0]     n_q, n_d;            // word count from the header
    logic [ADDR_W:0]     wl_q, wl_d;          // words written so far
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                cpu_rstn_q, cpu_rstn_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;        // running XOR of header and data bytes
`endif

    logic                accept;
    logic [31:0]         word;
    logic [ADDR_W:0]     wl_inc;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR;
            cnt_q      <= 2'd0;
            sr_q       <= 24'd0;
            n_q        <= '0;
            wl_q       <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            cpu_rstn_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            n_q        <= n_d;
            wl_q       <= wl_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_rstn_q <= cpu_rstn_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // Next-state and datapath: byte assembly, IM writes, end-of-image decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        n_d        = n_q;
        wl_d       = wl_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        accept     = in_valid && in_ready;
        word       = {in_data, sr_q};
        wl_inc     = wl_q + 1'b1;

        case (state_q)
            S_HDR, S_DATA: begin
                if (accept) begin
                    cnt_d = cnt_q + 2'd1;
                    sr_d  = {in_data, sr_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ in_data;
`endif
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_HDR) begin
                            n_d = word[ADDR_W:0];
                            if ({1'b0, word} > CAP) begin
                                state_d = S_ERR;
                            end else if (word == 32'd0) begin
                                state_d = END_STATE;
                            end else begin
                                state_d = S_DATA;
                            end
                        end else begin
                            im_we_d    = 1'b1;
                            im_addr_d  = wl_q[ADDR_W-1:0];
                            im_wdata_d = word;
                            wl_d       = wl_inc;
                            if (wl_inc == n_q) begin
                                state_d = END_STATE;
                            end
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d = S_HDR;
                    wl_d    = '0;
                    cnt_d   = 2'd0;
                    sr_d    = 24'd0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end
            end
            default: state_d = S_HDR;
        endcase

        // Release the core one edge after DONE is entered, so the final IM
        // write has already happened; drop it on the same edge as a reload.
        cpu_rstn_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    // Output decode: status from the state register, the rest from flops.
    always_comb begin
        in_ready     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
        busy         = in_ready;
        done         = (state_q == S_DONE);
        err          = (state_q == S_ERR);
        im_we        = im_we_q;
        im_addr      = im_addr_q;
        im_wdata     = im_wdata_q;
        cpu_rstn     = cpu_rstn_q;
        words_loaded = wl_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed images from the test plan plus random
// images, checked against a behavioural image model through a write queue.
// Covers both builds; LOADER_CHECKSUM_EN adds the checksum cases.
module tb_prog_loader;

    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;
    localparam int WQ     = ADDR_W + 32;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rstn;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [WQ-1:0] exp_q[$];
    logic [31:0]   img_w [0:CAP-1];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_rstn(cpu_rstn), .busy(busy), .done(done),
        .err(err), .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every IM write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         im_addr, im_wdata);
            end else begin
                check("im_write", {22'd0, im_addr, im_wdata}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        reload = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_addr", 64'(im_addr), 64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_cpu_rstn", 64'(cpu_rstn), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        // reload while loading must be ignored
        reload   = ($urandom_range(0, 7) == 0);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        in_valid = 1'b0;
        reload   = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_accept_timeout: got in_ready=0 for 20 cycles, expected 1");
        end
    endtask

    // Model: build the byte image for n words in img_w, push expected writes,
    // send it and check the end-of-image status.
    task automatic run_image(input logic [31:0] n, input int gap_min, input int gap_max,
                             input bit bad_csum);
        logic [7:0]      bytes[$];
        logic [7:0]      x;
        logic [7:0]      cs;
        bit              exp_done;
        logic [ADDR_W:0] exp_wl;
        bit              ok;
        x = 8'd0;
        for (int k = 0; k < 4; k++) begin
            bytes.push_back(n[8*k +: 8]);
            x ^= n[8*k +: 8];
        end
        if (n > 32'(CAP)) begin
            exp_done = 1'b0;
            exp_wl   = '0;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                for (int k = 0; k < 4; k++) begin
                    bytes.push_back(img_w[i][8*k +: 8]);
                    x ^= img_w[i][8*k +: 8];
                end
                exp_q.push_back({ADDR_W'(i), img_w[i]});
            end
            exp_wl   = n[ADDR_W:0];
            exp_done = 1'b1;
            if (CSUM_EN) begin
                cs = bad_csum ? (x ^ (8'd1 << $urandom_range(0, 7))) : x;
                bytes.push_back(cs);
                exp_done = !bad_csum;
            end
        end
        foreach (bytes[k]) begin
            send_byte(bytes[k], $urandom_range(gap_min, gap_max), ok);
            if (!ok) begin
                exp_q.delete();
                apply_reset();
                return;
            end
        end
        // First cycle after the last byte: final state reached, core still held.
        @(negedge clk);
        check("end_done", 64'(done), 64'(exp_done));
        check("end_err", 64'(err), 64'(!exp_done));
        check("end_in_ready", 64'(in_ready), 64'd0);
        check("end_cpu_rstn_held", 64'(cpu_rstn), 64'd0);
        tick();
        // One edge later: core released only on success, all writes seen.
        @(negedge clk);
        check("release_cpu_rstn", 64'(cpu_rstn), 64'(exp_done));
        check("words_loaded", 64'(words_loaded), 64'(exp_wl));
        check("im_we_single", 64'(im_we), 64'd0);
        check("writes_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
    endtask

    task automatic do_reload(input bit with_byte);
        reload = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        check("reload_in_ready", 64'(in_ready), 64'd0);
        tick();
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reload_busy", 64'(busy), 64'd1);
        check("reload_cpu_rstn", 64'(cpu_rstn), 64'd0);
        check("reload_words_loaded", 64'(words_loaded), 64'd0);
        tick();
    endtask

    task automatic load_nominal();
        img_w[0] = 32'h0050_0093;
        img_w[1] = 32'h0010_0113;
    endtask

    initial begin
        logic [31:0] n;
        bit          ok;

        apply_reset();
        check_reset_state();

        // Nominal two-word image, then the same image throttled by 3-cycle gaps.
        load_nominal();
        run_image(32'd2, 0, 0, 1'b0);
        do_reload(1'b0);
        load_nominal();
        run_image(32'd2, 3, 3, 1'b0);
        do_reload(1'b1);

        // Empty and oversize images.
        run_image(32'd0, 0, 1, 1'b0);
        do_reload(1'b0);
        run_image(32'd1025, 0, 1, 1'b0);
        do_reload(1'b1);

        // Corrupt checksum must end in ERR with the core held.
        if (CSUM_EN) begin
            load_nominal();
            run_image(32'd2, 0, 0, 1'b1);
            do_reload(1'b0);
        end

        // Full-capacity image.
        for (int i = 0; i < CAP; i++) img_w[i] = $urandom();
        run_image(32'(CAP), 0, 0, 1'b0);
        do_reload(1'b0);

        // Reset after two bytes of a data word: no write, back to an empty HDR.
        img_w[0] = $urandom();
        send_byte(8'd1, 0, ok);
        send_byte(8'd0, 0, ok);
        send_byte(8'd0, 0, ok);
        send_byte(8'd0, 0, ok);
        send_byte(8'hA5, 0, ok);
        send_byte(8'h5A, 0, ok);
        apply_reset();
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_words_loaded", 64'(words_loaded), 64'd0);
        check("midrst_im_we", 64'(im_we), 64'd0);
        tick();
        load_nominal();
        run_image(32'd2, 0, 1, 1'b0);
        do_reload(1'b1);

        // Random images.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 5) == 0) begin
                n = 32'(CAP + 1) + ($urandom() >> 1);
            end else begin
                n = 32'($urandom_range(0, 8));
                for (int i = 0; i < int'(n); i++) img_w[i] = $urandom();
            end
            run_image(n, 0, 2, CSUM_EN && ($urandom_range(0, 3) == 0));
            do_reload($urandom_range(0, 1) == 1);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
